// File: rtl/logic_gate_tester.sv
// ============================================================================
// Module   : logic_gate_tester
// Purpose  : BIST initiator that sweeps a/b over a 2-input gate unit and checks
//            its OR/AND/XOR/NOR/NAND/XNOR outputs against the truth table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_gate_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1,
    parameter int ERR_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             a_o,
    output logic             b_o,
    input  logic [5:0]       y_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [5:0]       fail_vec,
    output logic [1:0]       first_fail_ab
);

    localparam int CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
    localparam logic [CNT_W-1:0]  c_SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [LOOP_W-1:0] c_LOOP_LAST   = LOOP_W'(LOOPS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_CHECK  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    logic [1:0]         r_idx;
    logic [LOOP_W-1:0]  r_loop;
    logic [CNT_W-1:0]   r_settle;
    logic               r_a;
    logic               r_b;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [ERR_W-1:0]   r_err;
    logic [5:0]         r_fail_vec;
    logic [1:0]         r_first_fail;

    logic [5:0]         w_expected;
    logic [5:0]         w_mismatch;
    logic               w_any_mismatch;
    logic [ERR_W-1:0]   w_err_next;
    logic               w_last_vec;
    logic [1:0]         w_idx_next;
    state_t             w_vec_state;

    function automatic logic [5:0] f_expected(input logic [1:0] ab);
        case (ab)
            2'b00:   f_expected = 6'h38;
            2'b01:   f_expected = 6'h15;
            2'b10:   f_expected = 6'h15;
            default: f_expected = 6'h23;
        endcase
    endfunction

    assign w_expected = f_expected(r_idx);

    // if/else form so an X/Z on y_i lands in the mismatch branch
    always_comb begin
        w_mismatch = 6'b0;
        for (int i = 0; i < 6; i++) begin
            if (y_i[i] == w_expected[i])
                w_mismatch[i] = 1'b0;
            else
                w_mismatch[i] = 1'b1;
        end
    end

    assign w_any_mismatch = |w_mismatch;
    assign w_err_next     = (w_any_mismatch && (r_err != {ERR_W{1'b1}})) ? r_err + ERR_W'(1) : r_err;
    assign w_last_vec     = (r_idx == 2'd3) && (r_loop == c_LOOP_LAST);
    assign w_idx_next     = r_idx + 2'd1;
    assign w_vec_state    = (SETTLE_CYCLES == 0) ? S_CHECK : S_SETTLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_idx        <= 2'd0;
            r_loop       <= '0;
            r_settle     <= '0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= '0;
            r_fail_vec   <= 6'b0;
            r_first_fail <= 2'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_err        <= '0;
                        r_fail_vec   <= 6'b0;
                        r_first_fail <= 2'b0;
                        r_pass       <= 1'b0;
                        r_idx        <= 2'd0;
                        r_loop       <= '0;
                        r_settle     <= '0;
                        r_a          <= 1'b0;
                        r_b          <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= w_vec_state;
                    end
                end
                S_SETTLE: begin
                    if (r_settle == c_SETTLE_LAST) begin
                        r_settle <= '0;
                        r_state  <= S_CHECK;
                    end else begin
                        r_settle <= r_settle + CNT_W'(1);
                    end
                end
                S_CHECK: begin
                    r_err <= w_err_next;
                    if (w_any_mismatch) begin
                        r_fail_vec <= r_fail_vec | w_mismatch;
                        if (r_err == '0)
                            r_first_fail <= r_idx;
                    end
                    if (w_last_vec) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_pass  <= (w_err_next == '0);
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                    end else begin
                        r_idx <= w_idx_next;
                        if (r_idx == 2'd3)
                            r_loop <= r_loop + LOOP_W'(1);
                        r_a     <= w_idx_next[1];
                        r_b     <= w_idx_next[0];
                        r_state <= w_vec_state;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_o           = r_a;
    assign b_o           = r_b;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign err_cnt       = r_err;
    assign fail_vec      = r_fail_vec;
    assign first_fail_ab = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_logic_gate_tester.sv
// ============================================================================
// Module   : tb_logic_gate_tester
// Purpose  : Scoreboard bench for logic_gate_tester with three parameter sets
//            driving modelled gate units (correct and faulty variants).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_gate_tester;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_w [3];
    logic       a_w     [3];
    logic       b_w     [3];
    logic       busy_w  [3];
    logic       done_w  [3];
    logic       pass_w  [3];
    logic [5:0] y_w     [3];
    logic [5:0] fv_w    [3];
    logic [1:0] ff_w    [3];
    logic [3:0] err0;
    logic [1:0] err1;
    logic [3:0] err2;
    bit   [1:0] mode    [3];

    int cyc = 0;
    int run_start [3];
    int busy_cnt  [3];
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         dut;
        int         done_cyc;
        bit         pass;
        int         err;
        logic [5:0] fv;
        logic [1:0] ff;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode: 0 correct, 1 AND stuck-0, 2 all outputs inverted, 3 XOR stuck-1
    function automatic logic [5:0] gate(input logic a, input logic b, input bit [1:0] m);
        logic [5:0] y;
        y = {~(a ^ b), ~(a & b), ~(a | b), a ^ b, a & b, a | b};
        case (m)
            2'd1:    y[1] = 1'b0;
            2'd2:    y = ~y;
            2'd3:    y[2] = 1'b1;
            default: y = y;
        endcase
        return y;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_model
        assign y_w[g] = gate(a_w[g], b_w[g], mode[g]);
    end

    logic_gate_tester u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_w[0]), .a_o(a_w[0]), .b_o(b_w[0]),
        .y_i(y_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_cnt(err0), .fail_vec(fv_w[0]), .first_fail_ab(ff_w[0])
    );

    logic_gate_tester #(.ERR_W(2), .LOOPS(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_w[1]), .a_o(a_w[1]), .b_o(b_w[1]),
        .y_i(y_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_cnt(err1), .fail_vec(fv_w[1]), .first_fail_ab(ff_w[1])
    );

    logic_gate_tester #(.SETTLE_CYCLES(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_w[2]), .a_o(a_w[2]), .b_o(b_w[2]),
        .y_i(y_w[2]), .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_cnt(err2), .fail_vec(fv_w[2]), .first_fail_ab(ff_w[2])
    );

    function automatic int settle_of(input int i);
        return (i == 2) ? 0 : 2;
    endfunction

    function automatic int loops_of(input int i);
        return (i == 1) ? 2 : 1;
    endfunction

    function automatic int err_of(input int i);
        case (i)
            0:       return int'(err0);
            1:       return int'(err1);
            default: return int'(err2);
        endcase
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cyc=%0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input int i, input string nm);
        logic [12:0] v;
        v = {a_w[i], b_w[i], busy_w[i], done_w[i], pass_w[i], fv_w[i], ff_w[i]};
        chk($sformatf("%s_outs_dut%0d", nm, i), int'(v), 0);
        chk($sformatf("%s_err_dut%0d", nm, i), err_of(i), 0);
    endtask

    // Monitor: stimulus order while busy, and scoreboard pop on every done pulse
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (!rst_n) begin
                    busy_cnt[i] = 0;
                end else if (busy_w[i]) begin
                    k = cyc - run_start[i];
                    chk($sformatf("ab_seq_dut%0d_k%0d", i, k), int'({a_w[i], b_w[i]}),
                        (k / (settle_of(i) + 1)) % 4);
                    busy_cnt[i]++;
                end
                if (done_w[i]) begin
                    if (sb.size() == 0 || sb[0].dut != i) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_done dut%0d cyc=%0d", i, cyc);
                    end else begin
                        e = sb.pop_front();
                        chk($sformatf("done_cyc_dut%0d", i), cyc, e.done_cyc);
                        chk($sformatf("busy_len_dut%0d", i), busy_cnt[i],
                            4 * loops_of(i) * (settle_of(i) + 1));
                        chk($sformatf("pass_dut%0d", i), int'(pass_w[i]), int'(e.pass));
                        chk($sformatf("err_cnt_dut%0d", i), err_of(i), e.err);
                        chk($sformatf("fail_vec_dut%0d", i), int'(fv_w[i]), int'(e.fv));
                        if (e.err != 0)
                            chk($sformatf("first_fail_dut%0d", i), int'(ff_w[i]), int'(e.ff));
                    end
                    busy_cnt[i] = 0;
                end
            end
        end
    end

    task automatic push_exp(input int d, input int dc, input bit p, input int e,
                            input logic [5:0] fv, input logic [1:0] ff);
        exp_t x;
        x.dut = d; x.done_cyc = dc; x.pass = p; x.err = e; x.fv = fv; x.ff = ff;
        sb.push_back(x);
    endtask

    // Called on a negedge; the start is sampled at the following posedge.
    task automatic issue(input int d, input bit [1:0] m, input bit p, input int e,
                         input logic [5:0] fv, input logic [1:0] ff);
        mode[d]      = m;
        start_w[d]   = 1'b1;
        run_start[d] = cyc + 1;
        push_exp(d, cyc + 1 + 4 * loops_of(d) * (settle_of(d) + 1), p, e, fv, ff);
        @(negedge clk);
        start_w[d] = 1'b0;
    endtask

    task automatic wait_empty(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout_done: got=none expected=done within %0d cycles", maxc);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n0;
        for (int i = 0; i < 3; i++) begin
            start_w[i]   = 1'b0;
            mode[i]      = 2'd0;
            run_start[i] = 0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_zero(i, "reset");
        #2 rst_n = 1'b1;
        @(negedge clk);

        issue(0, 2'd0, 1'b1, 0, 6'h00, 2'b00);
        wait_empty(40);
        issue(0, 2'd1, 1'b0, 1, 6'h02, 2'b11);
        wait_empty(40);
        issue(0, 2'd3, 1'b0, 2, 6'h04, 2'b00);
        wait_empty(40);
        issue(1, 2'd2, 1'b0, 3, 6'h3F, 2'b00);
        wait_empty(60);
        issue(2, 2'd0, 1'b1, 0, 6'h00, 2'b00);
        wait_empty(20);
        issue(2, 2'd1, 1'b0, 1, 6'h02, 2'b11);
        wait_empty(20);

        // start held high across a whole run and the following DONE cycle
        mode[0]      = 2'd1;
        start_w[0]   = 1'b1;
        n0           = cyc + 1;
        run_start[0] = n0;
        push_exp(0, n0 + 12, 1'b0, 1, 6'h02, 2'b11);
        while (cyc < n0 + 12) @(negedge clk);
        mode[0]      = 2'd0;
        run_start[0] = n0 + 14;
        push_exp(0, n0 + 26, 1'b1, 0, 6'h00, 2'b00);
        @(negedge clk);
        chk("idle_after_done_busy", int'(busy_w[0]), 0);
        @(negedge clk);
        start_w[0] = 1'b0;
        wait_empty(40);

        // reset while vector 10 is in CHECK
        mode[0]      = 2'd2;
        start_w[0]   = 1'b1;
        n0           = cyc + 1;
        run_start[0] = n0;
        @(negedge clk);
        start_w[0] = 1'b0;
        while (cyc < n0 + 8) @(negedge clk);
        chk("ab_before_reset", int'({a_w[0], b_w[0]}), 2);
        chk("err_before_reset", err_of(0), 2);
        #2 rst_n = 1'b0;
        #1 chk_zero(0, "midrun_reset");
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("no_done_after_reset_busy", int'(busy_w[0]), 0);
        issue(0, 2'd0, 1'b1, 0, 6'h00, 2'b00);
        wait_empty(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
